fourteen_to_one_serializer_fsm: RTL

//  - Parallel-to-serial transmitter: takes a WIDTH-bit word, frames it with active-low ss, shifts it out MSB first on data_out.
//  - Feeds the team's 1-to-14 FSM deserializer, which shifts one bit per clock while its FSM is in INPUT.
//  - ss and data_out are timed so that receiver captures exactly WIDTH bits in order.
//  - Both ends share the same clock domain.

---
 rtl/fourteen_to_one_serializer_fsm_pkg.sv | 40 ++++
 rtl/fourteen_to_one_serializer_fsm_shreg.sv | 30 +++
 rtl/fourteen_to_one_serializer_fsm.sv | 102 ++++++++++
 3 files changed

// File: rtl/fourteen_to_one_serializer_fsm_pkg.sv
// Shared definitions for the 14-bit serializer and its matching deserializer.
// State codes and default word width are common to both ends of the link.
package fourteen_to_one_serializer_fsm_pkg;

  localparam int WIDTH_DEF = 14;
  localparam int CW_DEF    = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEND = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef struct packed {
    logic ss;
    logic data_out;
  } line_t;

  localparam line_t LINE_IDLE = '{
    ss:       1'b1,
    data_out: 1'b0
  };

  // 2'b11 is unreachable in normal operation; it falls back to IDLE.
  function automatic logic [1:0] fsm_next(
    input logic [1:0] s,
    input logic       load,
    input logic       ack,
    input logic       last
  );
    logic [1:0] n;
    n = IDLE;
    unique case (s)
      IDLE:    n = load ? SEND : IDLE;
      SEND:    n = last ? DONE : SEND;
      DONE:    n = ack  ? IDLE : DONE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fourteen_to_one_serializer_fsm_shreg.sv
// Parallel-load shift register presenting its MSB.
// Load wins over shift when both are asserted.
module shift_register_pload_msb
  import fourteen_to_one_serializer_fsm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (enable) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign q_msb = q[WIDTH-1];

endmodule

// File: rtl/fourteen_to_one_serializer_fsm.sv
// Framed MSB-first serializer: ss low for WIDTH cycles, data lags ss by one.
// Feeds the 1-to-14 FSM deserializer in the same clock domain.
module fourteen_to_one_serializer_fsm
  import fourteen_to_one_serializer_fsm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ack,
  output logic             ss,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       y_Q
);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          shifting;
  logic          last;
  logic          release_done;
  logic          illegal;
  logic          sh_msb;
  line_t         line_q;

  assign accept       = (state == IDLE) && load;
  assign shifting     = (state == SEND);
  assign last         = shifting && (cnt == CW'(WIDTH - 1));
  assign release_done = (state == DONE) && ack;
  assign illegal      = (state == 2'b11);
  assign state_n      = fsm_next(state, load, ack, last);

  shift_register_pload_msb #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk    (clock),
    .resetn (resetn),
    .load   (accept),
    .enable (shifting),
    .d      (data_in),
    .q_msb  (sh_msb)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (shifting) begin
      cnt <= cnt + 1'b1;
    end
  end

  // ss rises on the edge that launches the last bit, so data trails ss by one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      line_q <= LINE_IDLE;
    end else begin
      unique case (1'b1)
        accept: begin
          line_q.ss <= 1'b0;
        end
        shifting: begin
          line_q.data_out <= sh_msb;
          if (last) begin
            line_q.ss <= 1'b1;
          end
        end
        release_done: begin
          line_q.data_out <= 1'b0;
        end
        illegal: begin
          line_q <= LINE_IDLE;
        end
        default: begin
          line_q <= line_q;
        end
      endcase
    end
  end

  assign ss       = line_q.ss;
  assign data_out = line_q.data_out;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign y_Q      = state;

endmodule
